// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared constants for the pipelined Y86-64 execute-stage ALU:
//                OPq function encodings, condition-code bit positions and the
//                condition-code reset value.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef logic [1:0] alu_op_t;

    // Y86 OPq function codes (ifun field)
    localparam alu_op_t ALU_ADD = 2'd0;
    localparam alu_op_t ALU_SUB = 2'd1;
    localparam alu_op_t ALU_AND = 2'd2;
    localparam alu_op_t ALU_XOR = 2'd3;

    // Bit positions inside a {ZF, SF, OF} flag vector
    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

    // Architectural CC after reset: ZF set, SF/OF clear
    localparam logic [2:0] CC_RESET = 3'b100;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
//  Module      : alu_core
//  Description : Combinational Y86 OPq function unit. Computes B op A modulo
//                2^W and the {ZF, SF, OF} flags of that result.
//  Ports       : i_op     - function code (ADD/SUB/AND/XOR)
//                i_a      - valA
//                i_b      - valB
//                o_result - B op A
//                o_flags  - {ZF, SF, OF} of o_result
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_core
    import alu_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [1:0]   i_op,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_result,
    output logic [2:0]   o_flags
);

    logic [W-1:0] w_res;
    logic         w_of;

    always_comb begin
        w_res = '0;
        w_of  = 1'b0;
        case (i_op)
            ALU_ADD: begin
                w_res = i_b + i_a;
                // Like-signed operands producing a result of the other sign
                w_of  = (i_a[W-1] == i_b[W-1]) && (w_res[W-1] != i_b[W-1]);
            end
            ALU_SUB: begin
                w_res = i_b - i_a;
                // B - A overflows only when the operand signs differ
                w_of  = (i_a[W-1] != i_b[W-1]) && (w_res[W-1] != i_b[W-1]);
            end
            ALU_AND: w_res = i_b & i_a;
            ALU_XOR: w_res = i_b ^ i_a;
            default: w_res = '0;
        endcase
    end

    assign o_result       = w_res;
    assign o_flags[CC_ZF] = (w_res == '0);
    assign o_flags[CC_SF] = w_res[W-1];
    assign o_flags[CC_OF] = w_of;

endmodule : alu_core
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pipe
//  Description : Pipelined Y86-64 execute-stage ALU. The result is computed
//                combinationally at the input and captured in stage 1; later
//                stages only delay. Each stage has its own valid bit so that
//                bubbles collapse under back-pressure. The architectural CC
//                register updates only when a flagged operation retires.
//  Ports       : clk, rst_n            - clock, async active-low reset
//                flush                 - synchronous kill of in-flight ops
//                in_valid/in_ready     - input handshake
//                in_op, in_a, in_b     - function code, valA, valB
//                in_set_cc, in_tag     - CC-update request, sideband tag
//                out_valid/out_ready   - output handshake (retire)
//                out_result, out_tag   - result and tag of the oldest op
//                out_flags             - {ZF, SF, OF} of out_result
//                cc                    - architectural {ZF, SF, OF}
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe
    import alu_pkg::*;
#(
    parameter int W      = 64,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_set_cc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic [2:0]       out_flags,
    output logic [2:0]       cc
);

    localparam int LAST = STAGES - 1;

    logic [W-1:0]                  w_core_result;
    logic [2:0]                    w_core_flags;
    logic                          w_accept;
    logic                          w_retire;
    logic [STAGES-1:0]             w_load;
    logic [STAGES-1:0]             w_valid;
    logic [STAGES-1:0]             w_set_cc;
    logic [STAGES-1:0][W-1:0]      w_result;
    logic [STAGES-1:0][2:0]        w_flags;
    logic [STAGES-1:0][TAG_W-1:0]  w_tag;
    logic [2:0]                    r_cc;

    alu_core #(
        .W (W)
    ) u_core (
        .i_op     (in_op),
        .i_a      (in_a),
        .i_b      (in_b),
        .o_result (w_core_result),
        .o_flags  (w_core_flags)
    );

    // Load chain from the output backwards: a stage may take new contents
    // when it is empty or when its downstream neighbour is taking its own.
    always_comb begin
        logic l_load;
        l_load       = !w_valid[LAST] || out_ready;
        w_load[LAST] = l_load;
        for (int i = LAST - 1; i >= 0; i--) begin
            l_load    = !w_valid[i] || l_load;
            w_load[i] = l_load;
        end
    end

    // rst_n gates in_ready so nothing is handshaken while reset is held
    assign in_ready = rst_n && !flush && w_load[0];
    assign w_accept = in_valid && in_ready;
    assign w_retire = w_valid[LAST] && out_ready;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic             r_v;
        logic             r_sc;
        logic [W-1:0]     r_res;
        logic [2:0]       r_fl;
        logic [TAG_W-1:0] r_tg;
        logic             w_up_v;
        logic             w_up_sc;
        logic [W-1:0]     w_up_res;
        logic [2:0]       w_up_fl;
        logic [TAG_W-1:0] w_up_tg;

        if (gi == 0) begin : g_head
            assign w_up_v   = w_accept;
            assign w_up_sc  = in_set_cc;
            assign w_up_res = w_core_result;
            assign w_up_fl  = w_core_flags;
            assign w_up_tg  = in_tag;
        end else begin : g_body
            assign w_up_v   = w_valid[gi-1];
            assign w_up_sc  = w_set_cc[gi-1];
            assign w_up_res = w_result[gi-1];
            assign w_up_fl  = w_flags[gi-1];
            assign w_up_tg  = w_tag[gi-1];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v   <= 1'b0;
                r_sc  <= 1'b0;
                r_res <= '0;
                r_fl  <= '0;
                r_tg  <= '0;
            end else begin
                if (flush) begin
                    r_v <= 1'b0;
                end else if (w_load[gi]) begin
                    r_v <= w_up_v;
                end
                // Payload only moves with real data, so a held output and
                // drained bubbles never disturb the visible fields.
                if (w_load[gi] && w_up_v) begin
                    r_sc  <= w_up_sc;
                    r_res <= w_up_res;
                    r_fl  <= w_up_fl;
                    r_tg  <= w_up_tg;
                end
            end
        end

        assign w_valid[gi]  = r_v;
        assign w_set_cc[gi] = r_sc;
        assign w_result[gi] = r_res;
        assign w_flags[gi]  = r_fl;
        assign w_tag[gi]    = r_tg;
    end

    // CC follows retirement (not issue), so it stays in program order and a
    // retire coinciding with a flush still commits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cc <= CC_RESET;
        end else if (w_retire && w_set_cc[LAST]) begin
            r_cc <= w_flags[LAST];
        end
    end

    assign out_valid  = w_valid[LAST];
    assign out_result = w_result[LAST];
    assign out_tag    = w_tag[LAST];
    assign out_flags  = w_flags[LAST];
    assign cc         = r_cc;

endmodule : alu_pipe
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_pipe
//  Description : Self-checking bench for alu_pipe (W = 64, STAGES = 2).
//                Directed scenarios followed by randomized traffic, all
//                checked against an in-bench reference model: a queue of
//                accepted operations whose results come from wide signed
//                arithmetic, plus a model of the architectural CC.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;

    localparam int W      = 64;
    localparam int STAGES = 2;
    localparam int TAG_W  = 4;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic             in_set_cc;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_result;
    logic [TAG_W-1:0] out_tag;
    logic [2:0]       out_flags;
    logic [2:0]       cc;

    alu_pipe #(
        .W      (W),
        .STAGES (STAGES),
        .TAG_W  (TAG_W)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_set_cc  (in_set_cc),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_flags  (out_flags),
        .cc         (cc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]     res;
        logic [2:0]       flags;
        logic [TAG_W-1:0] tag;
        bit               sc;
    } exp_t;

    exp_t       q[$];
    logic [2:0] m_cc;
    int         checks;
    int         errors;
    int         n_valid;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: exact signed arithmetic; overflow means the true value does
    // not fit back into W bits.
    function automatic exp_t ref_alu(input logic [1:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b, input bit sc,
                                     input logic [TAG_W-1:0] tag);
        exp_t                e;
        logic signed [W:0]   wide;
        bit                  of;
        of   = 1'b0;
        wide = '0;
        case (op)
            2'd0: begin
                wide = $signed({b[W-1], b}) + $signed({a[W-1], a});
                e.res = wide[W-1:0];
                of = (wide != $signed({e.res[W-1], e.res}));
            end
            2'd1: begin
                wide = $signed({b[W-1], b}) - $signed({a[W-1], a});
                e.res = wide[W-1:0];
                of = (wide != $signed({e.res[W-1], e.res}));
            end
            2'd2:    e.res = b & a;
            default: e.res = b ^ a;
        endcase
        e.flags = {e.res == 0, e.res[W-1], of};
        e.tag   = tag;
        e.sc    = sc;
        return e;
    endfunction

    // One clock cycle: called at a negedge, applies inputs, checks the
    // handshake against the model, steps the model, then checks CC.
    task automatic cycle(input bit v, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit sc, input logic [TAG_W-1:0] tag,
                         input bit ordy, input bit fl);
        exp_t e;
        bit   acc;
        bit   ret;
        in_valid  = v;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_set_cc = sc;
        in_tag    = tag;
        out_ready = ordy;
        flush     = fl;
        #1;
        check("in_ready", in_ready, (!fl && (q.size() < STAGES || ordy)) ? 1 : 0);
        acc = in_valid && in_ready;
        ret = out_valid && out_ready;
        if (ret) begin
            check("retire_expected", q.size() > 0 ? 1 : 0, 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("out_result", out_result, e.res);
                check("out_tag", out_tag, e.tag);
                check("out_flags", out_flags, e.flags);
                if (e.sc) m_cc = e.flags;
            end
        end
        if (fl) q.delete();
        else if (acc) q.push_back(ref_alu(op, a, b, sc, tag));
        @(posedge clk);
        #1;
        check("cc", cc, m_cc);
        @(negedge clk);
    endtask

    task automatic idle(input bit ordy);
        cycle(1'b0, 2'd0, '0, '0, 1'b0, '0, ordy, 1'b0);
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] corner [6];
        corner[0] = 64'h0;
        corner[1] = 64'h1;
        corner[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        corner[3] = 64'h7FFF_FFFF_FFFF_FFFF;
        corner[4] = 64'h8000_0000_0000_0000;
        corner[5] = 64'h5555_5555_5555_5555;
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 5)];
        return {$urandom, $urandom};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        m_cc   = 3'b100;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
        in_set_cc = 1'b0; in_tag = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_cc", cc, 3'b100);
        check("rst_out_result", out_result, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_out_flags", out_flags, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: ADD 1 + (-2) with CC update, latency 2
        cycle(1, 2'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1, 4'd5, 1, 0);
        check("t1_lat_not_yet", out_valid, 0);
        idle(1);
        check("t1_out_valid", out_valid, 1);
        check("t1_result", out_result, 64'hFFFF_FFFF_FFFF_FFFF);
        check("t1_flags", out_flags, 3'b010);
        idle(1);
        check("t1_cc", cc, 3'b010);

        // 2: ADD overflow, then SUB overflow, back to back
        cycle(1, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1, 4'd6, 1, 0);
        cycle(1, 2'd1, 64'd1, 64'h8000_0000_0000_0000, 1, 4'd7, 1, 0);
        check("t2_add_result", out_result, 64'hFFFF_FFFF_FFFF_FFFE);
        check("t2_add_flags", out_flags, 3'b011);
        idle(1);
        check("t2_sub_result", out_result, 64'h7FFF_FFFF_FFFF_FFFF);
        check("t2_sub_flags", out_flags, 3'b001);
        idle(1);
        check("t2_cc", cc, 3'b001);

        // 3: SUB to zero without CC update
        cycle(1, 2'd1, 64'd10000, 64'd10000, 0, 4'd8, 1, 0);
        idle(1);
        check("t3_result", out_result, 0);
        check("t3_flags", out_flags, 3'b100);
        idle(1);
        check("t3_cc", cc, 3'b001);

        // 4: back-pressure, tags 1,2,3 offered with out_ready low
        cycle(1, 2'd2, pick(), pick(), 0, 4'd1, 0, 0);
        cycle(1, 2'd3, pick(), pick(), 0, 4'd2, 0, 0);
        cycle(1, 2'd0, 64'd3, 64'd4, 1, 4'd3, 0, 0);
        check("t4_full_in_ready", in_ready, 0);
        check("t4_tag_stable", out_tag, 1);
        cycle(1, 2'd0, 64'd3, 64'd4, 1, 4'd3, 0, 0);
        check("t4_tag_stable2", out_tag, 1);
        n_valid = 0;
        cycle(1, 2'd0, 64'd3, 64'd4, 1, 4'd3, 1, 0);
        for (int i = 0; i < 2; i++) begin
            if (out_valid) n_valid++;
            idle(1);
        end
        check("t4_consecutive", n_valid, 2);
        check("t4_drained", q.size(), 0);
        check("t4_cc", cc, 3'b000);

        // flush coinciding with a retire: retire still commits CC
        cycle(1, 2'd1, 64'd5, 64'd3, 1, 4'd9, 1, 0);
        cycle(1, 2'd0, 64'd1, 64'd1, 1, 4'd10, 1, 0);
        cycle(1, 2'd0, 64'd2, 64'd2, 1, 4'd11, 1, 1);
        check("flush_ret_valid", out_valid, 0);
        check("flush_ret_cc", cc, 3'b010);

        // 5: flush with two ops stalled and a new op offered
        cycle(1, 2'd0, 64'd0, 64'd0, 1, 4'd12, 0, 0);
        cycle(1, 2'd0, 64'd0, 64'd0, 1, 4'd13, 0, 0);
        cycle(1, 2'd0, 64'd0, 64'd0, 1, 4'd14, 0, 1);
        check("t5_out_valid", out_valid, 0);
        idle(1);
        check("t5_nothing_taken", out_valid, 0);
        check("t5_cc", cc, 3'b010);

        // 6: asynchronous reset between edges with the pipe full
        cycle(1, 2'd3, pick(), pick(), 1, 4'd1, 0, 0);
        cycle(1, 2'd3, pick(), pick(), 1, 4'd2, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_out_valid", out_valid, 0);
        check("t6_cc", cc, 3'b100);
        check("t6_in_ready", in_ready, 0);
        q.delete();
        m_cc = 3'b100;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 2'd0, 64'd20, 64'd22, 1, 4'd4, 1, 0);
        idle(1);
        check("t6_post_valid", out_valid, 1);
        check("t6_post_result", out_result, 64'd42);
        idle(1);
        check("t6_post_cc", cc, 3'b000);

        // Randomized traffic with back-pressure and occasional flush
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), pick(), pick(),
                  $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
        end
        for (int i = 0; i < 10 && q.size() > 0; i++) idle(1);
        check("drain_empty", q.size(), 0);
        check("drain_out_valid", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_alu_pipe
`default_nettype wire
